bullet_scheduler: RTL
=====================

BULLET_SCHEDULER -- requirements
Module: bullet_scheduler

Interface
REQ-001 SHALL have parameter N_SLOTS, default 8: number of bullet FSMs served, range 2..16.
REQ-002 SHALL have parameter PERIOD, default 25: clk_100Hz cycles between launches, minimum 4.
REQ-003 SHALL have parameter VX_16X, default 8'd32: launch x-velocity, 1/16 px per tick.
REQ-004 SHALL have parameters VY_MAX, default 13'sd48, and VY_STEP, default 13'sd16: vy sweep bound and increment, signed.
REQ-005 SHALL have ports: clk_100Hz  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: enable  in  1  launching allowed; slot_busy  in  N_SLOTS  bit i high = bullet i in flight.
REQ-007 SHALL have ports: origin_x  in  10  launch x in px; origin_y  in  9  launch y in px.
REQ-008 SHALL have ports: fire  out  N_SLOTS  one-hot launch pulse; x_din  out  10; y_din  out  9; vx_din_16x  out  8; vy_din_16x  out  13 signed.
REQ-009 SHALL have ports: shot_cnt  out  16  successful launches; drop_cnt  out  8  skipped launches; active_cnt  out  5  popcount of slot_busy.

Function
REQ-010 SHALL implement states IDLE, COUNT, SEEK, FIRE; all outputs except active_cnt registered.
REQ-011 IDLE: enable=1 -> COUNT with cooldown counter = PERIOD-3; otherwise stay IDLE.
REQ-012 COUNT: counter decrements by 1 per cycle; counter=0 -> SEEK next cycle.
REQ-013 SEEK: round-robin search of ~slot_busy beginning at pointer ptr, wrapping at N_SLOTS-1 -> 0; the first free index found is the winner; search completes in one cycle.
REQ-014 SEEK with winner w: -> FIRE; fire registered to one-hot bit w; x_din <= origin_x; y_din <= origin_y; vx_din_16x <= VX_16X; vy_din_16x <= current sweep value; ptr <= (w+1) mod N_SLOTS.
REQ-015 SEEK with no free slot: -> COUNT with counter = PERIOD-2; drop_cnt += 1, saturating at 255; ptr and the vy sweep unchanged; fire stays 0.
REQ-016 FIRE: fire high exactly this one cycle, with x_din/y_din/vx_din_16x/vy_din_16x valid in the same cycle; -> COUNT with counter = PERIOD-3; shot_cnt += 1, wrapping at 65535.
REQ-017 Launch parameter outputs SHALL hold their last value until the next FIRE.
REQ-018 Fire-to-fire spacing with continuous free slots SHALL be exactly PERIOD cycles; after enable rises in IDLE, the first fire SHALL occur PERIOD cycles later.
REQ-019 Vy sweep SHALL start at -VY_MAX and direction up, and advance on each FIRE only.
  - Direction up: if vy+VY_STEP > VY_MAX, reverse direction and use vy-VY_STEP; otherwise use vy+VY_STEP.
  - Direction down: the mirror of the up rule, bounded by -VY_MAX.
REQ-020 The sweep SHALL use 13-bit signed arithmetic with no overflow for legal parameters.
REQ-021 enable=0 in COUNT, SEEK or FIRE SHALL move to IDLE at the next edge.
  - A fire already registered in FIRE completes its single cycle.
  - No new fire SHALL follow.
  - ptr, the vy sweep and the counters are retained.
REQ-022 A slot fired in cycle t SHALL NOT be considered before the next SEEK; PERIOD>=4 guarantees slot_busy feedback (1-cycle latency) is visible by then.
REQ-023 active_cnt SHALL be combinational popcount(slot_busy), 0..N_SLOTS.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE and clear fire, ptr and the counter.
REQ-025 rst SHALL set x_din, y_din and vx_din_16x to 0.
REQ-026 rst SHALL set vy_din_16x to 0, vy sweep to -VY_MAX, direction up, and shot_cnt and drop_cnt to 0.
REQ-027 rst SHALL take priority over enable and over any state, including mid-FIRE: fire is 0 in the cycle after the reset edge.

Verification
REQ-028 Defaults, all slot_busy=0, enable raised at cycle 0 -> fire=8'h01 at cycle 25, then 8'h02 at cycle 50, 8'h04 at cycle 75; shot_cnt increments on each.
REQ-029 Seven consecutive fires -> vy_din_16x sequence -48,-32,-16,0,16,32,48; 8th=32, 9th=16.
REQ-030 slot_busy=8'hFF held for 3 launch slots -> fire never asserted; drop_cnt=3; vy unchanged.
  - Then set slot_busy=8'hFB -> next fire=8'h04 on the original PERIOD grid.
REQ-031 ptr=6, slot_busy=8'hC1 -> winner wraps to slot 1: fire=8'h02, ptr becomes 2.
REQ-032 rst pulsed in the FIRE cycle -> fire=0 the following cycle; all counters 0; next first fire PERIOD cycles after rst drops with enable=1.
REQ-033 enable dropped mid-COUNT, raised 10 cycles later -> no fire while low; first fire PERIOD cycles after re-enable; vy continues the sweep from its retained value.

Source files
------------

// File: rtl/bullet_scheduler.sv
// Bullet launch scheduler: every PERIOD cycles, picks the next free bullet
// slot round-robin, pulses its fire bit and presents the launch position and
// velocity. Launches that find every slot busy are counted as drops. The
// vertical velocity sweeps back and forth between -VY_MAX and +VY_MAX.
module bullet_scheduler #(
    parameter int                  N_SLOTS = 8,
    parameter int                  PERIOD  = 25,
    parameter logic [7:0]          VX_16X  = 8'd32,
    parameter logic signed [12:0]  VY_MAX  = 13'sd48,
    parameter logic signed [12:0]  VY_STEP = 13'sd16
) (
    input  logic                clk_100Hz,
    input  logic                rst,
    input  logic                enable,
    input  logic [N_SLOTS-1:0]  slot_busy,
    input  logic [9:0]          origin_x,
    input  logic [8:0]          origin_y,
    output logic [N_SLOTS-1:0]  fire,
    output logic [9:0]          x_din,
    output logic [8:0]          y_din,
    output logic [7:0]          vx_din_16x,
    output logic signed [12:0]  vy_din_16x,
    output logic [15:0]         shot_cnt,
    output logic [7:0]          drop_cnt,
    output logic [4:0]          active_cnt
);

    localparam int PTR_W = $clog2(N_SLOTS);
    localparam int CNT_W = $clog2(PERIOD);

    // FIRE costs one cycle, so after a launch the cooldown is one shorter
    // than after a drop; both keep launch decisions on a PERIOD grid.
    localparam logic [CNT_W-1:0] RELOAD_FIRE = CNT_W'(PERIOD - 3);
    localparam logic [CNT_W-1:0] RELOAD_DROP = CNT_W'(PERIOD - 2);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        SEEK,
        FIRE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [PTR_W-1:0]        ptr;
    logic [PTR_W-1:0]        winner;
    logic                    found;
    logic [2*N_SLOTS-1:0]    busy_rot;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_load_val;
    logic                    cnt_load;
    logic                    cnt_dec;
    logic                    do_launch;
    logic                    do_drop;
    logic                    do_shot;
    logic signed [12:0]      vy;
    logic signed [12:0]      vy_next;
    logic                    vy_up;
    logic                    vy_up_next;

    // Round-robin search: rotate the busy vector so ptr lands at bit 0, then
    // take the first free bit.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        busy_rot = {slot_busy, slot_busy} >> ptr;
        found    = 1'b0;
        winner   = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (!found && !busy_rot[k]) begin
                found  = 1'b1;
                winner = PTR_W'((int'(ptr) + k) % N_SLOTS);
            end
        end
    end

    // Next vy sweep value: bounce off +/-VY_MAX by reversing direction.
    always_comb begin
        vy_next    = vy;
        vy_up_next = vy_up;
        if (vy_up) begin
            if (vy + VY_STEP > VY_MAX) begin
                vy_up_next = 1'b0;
                vy_next    = vy - VY_STEP;
            end else begin
                vy_next    = vy + VY_STEP;
            end
        end else begin
            if (vy - VY_STEP < -VY_MAX) begin
                vy_up_next = 1'b1;
                vy_next    = vy + VY_STEP;
            end else begin
                vy_next    = vy - VY_STEP;
            end
        end
    end

    // State register.
    always_ff @(posedge clk_100Hz) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control; dropping enable parks in IDLE.
    always_comb begin
        state_next   = state;
        cnt_load     = 1'b0;
        cnt_load_val = RELOAD_FIRE;
        cnt_dec      = 1'b0;
        do_launch    = 1'b0;
        do_drop      = 1'b0;
        do_shot      = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = COUNT;
                    cnt_load   = 1'b1;
                end
            end
            COUNT: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (cnt == '0) begin
                    state_next = SEEK;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            SEEK: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (found) begin
                    state_next = FIRE;
                    do_launch  = 1'b1;
                end else begin
                    state_next   = COUNT;
                    cnt_load     = 1'b1;
                    cnt_load_val = RELOAD_DROP;
                    do_drop      = 1'b1;
                end
            end
            FIRE: begin
                // The pulse already on the output completes either way.
                do_shot = 1'b1;
                if (!enable) begin
                    state_next = IDLE;
                end else begin
                    state_next = COUNT;
                    cnt_load   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Cooldown counter, round-robin pointer, sweep and registered outputs.
    always_ff @(posedge clk_100Hz) begin
        if (rst) begin
            cnt        <= '0;
            ptr        <= '0;
            vy         <= -VY_MAX;
            vy_up      <= 1'b1;
            fire       <= '0;
            x_din      <= '0;
            y_din      <= '0;
            vx_din_16x <= '0;
            vy_din_16x <= '0;
            shot_cnt   <= '0;
            drop_cnt   <= '0;
        end else begin
            fire <= '0;
            if (cnt_load) begin
                cnt <= cnt_load_val;
            end else if (cnt_dec) begin
                cnt <= cnt - 1'b1;
            end
            if (do_launch) begin
                fire[winner] <= 1'b1;
                x_din        <= origin_x;
                y_din        <= origin_y;
                vx_din_16x   <= VX_16X;
                vy_din_16x   <= vy;
                vy           <= vy_next;
                vy_up        <= vy_up_next;
                ptr          <= PTR_W'((int'(winner) + 1) % N_SLOTS);
            end
            if (do_drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            if (do_shot) begin
                shot_cnt <= shot_cnt + 16'd1;
            end
        end
    end

    // Number of bullets currently in flight.
    always_comb begin
        active_cnt = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            active_cnt = active_cnt + 5'(slot_busy[i]);
        end
    end

endmodule
